// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory controller.
//   F3_*            RISC-V load/store size codes
//   REQ_CORE/DBG    requester indices into the 2-wide request/response vectors
//   dmem_state_t    controller FSM states
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic {IDLE, RMW_WR} dmem_state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering.
//   i_rdata/i_off/i_funct3 -> o_ldata   : extracted and sign/zero-extended load data
//   i_old/i_wdata/i_off    -> o_merged  : old word with the B/H lane replaced by wdata
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_ldata,
  output logic [XLEN-1:0] o_merged
);
  logic [4:0]      w_sh;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_ins;

  assign w_sh   = {i_off, 3'b000};
  assign w_lane = i_rdata >> w_sh;

  always_comb begin
    o_ldata = '0;
    case (i_funct3)
      F3_B:  o_ldata = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      F3_BU: o_ldata = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      F3_H:  o_ldata = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      F3_HU: o_ldata = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      F3_W:  o_ldata = i_rdata;
      default: o_ldata = '0;
    endcase
  end

  // Stores ignore the unsigned bit, so only the size bits pick the lane width.
  always_comb begin
    w_mask = '1;
    w_ins  = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_mask = {{(XLEN-8){1'b0}}, 8'hFF} << w_sh;
        w_ins  = {{(XLEN-8){1'b0}}, i_wdata[7:0]} << w_sh;
      end
      2'b01: begin
        w_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << w_sh;
        w_ins  = {{(XLEN-16){1'b0}}, i_wdata[15:0]} << w_sh;
      end
      default: ;
    endcase
  end

  assign o_merged = (i_old & ~w_mask) | (w_ins & w_mask);
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-requester data-memory controller (core = 0, debug = 1).
//   req_*   : request vectors, held stable until req_gnt
//   req_gnt : combinational one-hot grant (IDLE only)
//   rsp_*   : registered one-cycle completion pulse, error flag, load data
//   mem_*   : single-port word memory; mem_rdata is combinational of mem_addr
// Sub-word stores are read in the grant cycle and written in RMW_WR.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_we,
  input  logic [1:0][2:0]      req_funct3,
  input  logic [1:0][XLEN-1:0] req_addr,
  input  logic [1:0][XLEN-1:0] req_wdata,
  output logic [1:0]           req_gnt,
  output logic [1:0]           rsp_valid,
  output logic [1:0]           rsp_err,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata
);
  localparam logic [XLEN-1:0] ADDR_LIM = XLEN'(MEM_DEPTH * 4);

  dmem_state_t     r_state, w_next;
  logic            r_rr_ptr;
  logic            r_idx;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_merged;
  logic [1:0]      r_rsp_valid, r_rsp_err;
  logic [XLEN-1:0] r_rdata;

  logic            w_idx, w_take, w_err, w_rmw;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_addr, w_wd, w_ldata, w_merged;
  logic [1:0]      w_onehot;

  // Single requester wins outright; on contention rr_ptr decides.
  assign w_idx    = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
  assign w_take   = (r_state == IDLE) && (|req_valid);
  assign w_onehot = 2'b01 << w_idx;
  assign w_f3     = req_funct3[w_idx];
  assign w_addr   = req_addr[w_idx];
  assign w_wd     = req_wdata[w_idx];

  assign w_err = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11)
              || ((w_f3[1:0] == 2'b01) && w_addr[0])
              || ((w_f3 == F3_W) && (w_addr[1:0] != 2'b00))
              || (w_addr >= ADDR_LIM);
  assign w_rmw = !w_err && req_we[w_idx] && (w_f3[1:0] != 2'b10);

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .i_rdata  (mem_rdata),
    .i_old    (mem_rdata),
    .i_wdata  (w_wd),
    .i_off    (w_addr[1:0]),
    .i_funct3 (w_f3),
    .o_ldata  (w_ldata),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_gnt   = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: if (w_take) begin
        req_gnt = w_onehot;
        if (!w_err) begin
          mem_valid = 1'b1;
          mem_addr  = {w_addr[XLEN-1:2], 2'b00};
          if (req_we[w_idx] && !w_rmw) begin
            mem_we    = 1'b1;
            mem_wdata = w_wd;
          end
          if (w_rmw) w_next = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_merged;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= REQ_CORE;
      r_idx       <= REQ_CORE;
      r_addr      <= '0;
      r_merged    <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      if (w_take) begin
        if (req_valid == 2'b11) r_rr_ptr <= ~w_idx;
        if (w_rmw) begin
          r_idx    <= w_idx;
          r_addr   <= {w_addr[XLEN-1:2], 2'b00};
          r_merged <= w_merged;
        end else begin
          r_rsp_valid <= w_onehot;
          r_rsp_err   <= w_err ? w_onehot : 2'b00;
          r_rdata     <= (w_err || req_we[w_idx]) ? '0 : w_ldata;
        end
      end else if (r_state == RMW_WR) begin
        r_rsp_valid <= 2'b01 << r_idx;
        r_rdata     <= '0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed + randomized checks of dmem_ctrl against a
// byte-addressed reference memory model.
module tb_dmem_ctrl;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_we;
  logic [1:0][2:0]   req_funct3;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        req_gnt, rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic              mem_valid, mem_we;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] env_mem [0:1023];   // the attached data_memory
  logic [7:0]  ref_mem [0:4095];   // reference model, byte granular
  int          ref_ptr;            // requester favoured on contention

  always #5 clk = ~clk;

  assign mem_rdata = env_mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_valid && mem_we) env_mem[mem_addr[11:2]] <= mem_wdata;

  dmem_ctrl #(.XLEN(32), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return a >= 32'd4096;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'(a & ~32'd3);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b = ref_mem[a];
    logic [15:0] h = {ref_mem[a+1], ref_mem[a]};
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  // One uncontested transaction by requester idx, fully checked.
  task automatic xact(input int idx, input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit err, rmw;
    int waited;
    logic [31:0] exp_rd, wa, oh;
    err    = ref_err(f3, a);
    rmw    = !err && we && (f3[1:0] != 2'b10);
    exp_rd = (err || we) ? 32'd0 : ref_load(f3, a);
    wa     = a & ~32'd3;
    oh     = 32'd1 << idx;
    req_valid = 2'b00;
    req_valid[idx] = 1'b1; req_we[idx] = we; req_funct3[idx] = f3;
    req_addr[idx] = a; req_wdata[idx] = wd;
    waited = 0;
    @(negedge clk);
    while (!req_gnt[idx] && waited < 20) begin @(negedge clk); waited++; end
    chk("gnt", {30'd0, req_gnt}, oh);
    chk("grant_mem_valid", {31'd0, mem_valid}, {31'd0, !err});
    chk("grant_mem_we", {31'd0, mem_we}, {31'd0, we && !err && !rmw});
    if (!err) chk("grant_mem_addr", mem_addr, wa);
    if (we && !err && !rmw) chk("sw_wdata", mem_wdata, wd);
    if (we && !err) ref_store(f3, a, wd);
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (rmw) begin
      chk("rmw_no_early_rsp", {30'd0, rsp_valid}, 32'd0);
      // the other requester knocks during RMW_WR and must be ignored
      req_valid[idx ^ 1] = 1'b1; req_we[idx ^ 1] = 1'b0;
      req_funct3[idx ^ 1] = 3'd2; req_addr[idx ^ 1] = 32'd0;
      @(negedge clk);
      chk("rmw_gnt_blocked", {30'd0, req_gnt}, 32'd0);
      chk("rmw_mem_we", {31'd0, mem_we}, 32'd1);
      chk("rmw_mem_addr", mem_addr, wa);
      chk("rmw_mem_wdata", mem_wdata, ref_word(wa));
      @(posedge clk); #1;
      req_valid = 2'b00;
    end
    chk("rsp_valid", {30'd0, rsp_valid}, oh);
    chk("rsp_err", {30'd0, rsp_err}, err ? oh : 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    if (a < 32'd4096) chk("mem_word", env_mem[a[11:2]], ref_word(wa));
    rd = rsp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  f3s [8];
    int idx;
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 1024; i++) env_mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    ref_ptr = 0;
    rst = 1'b0; req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_gnt", {30'd0, req_gnt}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_valid, mem_we}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // word, byte and halfword traffic
    xact(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    xact(0, 0, 3'd2, 32'h10, 32'h0, rd);         chk("lw_const", rd, 32'hDEADBEEF);
    xact(0, 1, 3'd2, 32'h20, 32'h11223344, rd);
    xact(0, 1, 3'd0, 32'h22, 32'h000000AA, rd);
    chk("sb_merged_const", env_mem[8], 32'h11AA3344);
    xact(0, 0, 3'd0, 32'h22, 32'h0, rd);         chk("lb_const", rd, 32'hFFFFFFAA);
    xact(1, 0, 3'd4, 32'h22, 32'h0, rd);         chk("lbu_const", rd, 32'h000000AA);
    xact(0, 1, 3'd1, 32'h26, 32'h12348001, rd);
    xact(0, 0, 3'd1, 32'h26, 32'h0, rd);         chk("lh_const", rd, 32'hFFFF8001);
    xact(1, 0, 3'd5, 32'h26, 32'h0, rd);         chk("lhu_const", rd, 32'h00008001);

    // errors
    xact(0, 0, 3'd2, 32'h02, 32'h0, rd);
    xact(0, 1, 3'd1, 32'h05, 32'hFFFF, rd);
    xact(1, 1, 3'd3, 32'h10, 32'h0, rd);
    xact(0, 0, 3'd2, 32'h1000, 32'h0, rd);
    xact(1, 1, 3'd2, 32'hFFC, 32'hCAFEF00D, rd);  // last in-range word
    xact(1, 0, 3'd2, 32'hFFC, 32'h0, rd);

    // contention: both hold LW, grants alternate starting from core
    req_valid = 2'b11; req_we = 2'b00; req_funct3[0] = 3'd2; req_funct3[1] = 3'd2;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arb_order", {30'd0, req_gnt}, 32'd1 << ref_ptr);
      if (k > 0) begin
        chk("arb_rsp", {30'd0, rsp_valid}, 32'd1 << (1 - ref_ptr));
        chk("arb_rdata", rsp_rdata, ref_word(ref_ptr == 0 ? 32'h20 : 32'h10));
      end
      ref_ptr = 1 - ref_ptr;
    end
    @(posedge clk); #1;
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dbg_alone", {30'd0, req_gnt}, 32'd2);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      idx = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      f3  = f3s[$urandom_range(0, 7)];
      if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 7));
        1:       a = 32'hFFC + 32'($urandom_range(0, 3));
        default: a = 32'h80 + 32'($urandom_range(0, 31));
      endcase
      xact(idx, we, f3, a, $urandom, rd);
    end

    // reset in RMW_WR: set rr_ptr to debug first, then abort an SB
    xact(0, 1, 3'd2, 32'h40, 32'h55667788, rd);
    req_valid = 2'b11; req_we = 2'b00; req_funct3[0] = 3'd2; req_funct3[1] = 3'd2;
    req_addr[0] = 32'h40; req_addr[1] = 32'h10;
    @(negedge clk);
    chk("pre_rst_arb", {30'd0, req_gnt}, 32'd1 << ref_ptr);
    ref_ptr = 1 - ref_ptr;
    @(posedge clk); #1;
    req_valid = 2'b01; req_we[0] = 1'b1; req_funct3[0] = 3'd0;
    req_addr[0] = 32'h41; req_wdata[0] = 32'h99;
    @(negedge clk);
    chk("abort_gnt", {30'd0, req_gnt}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2 rst = 1'b0; ref_ptr = 0;
    #1 chk("abort_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    chk("abort_no_rsp", {30'd0, rsp_valid}, 32'd0);
    chk("abort_word_kept", env_mem[16], 32'h55667788);
    @(posedge clk); #1;
    chk("abort_no_rsp2", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11; req_we = 2'b00; req_funct3[0] = 3'd2; req_funct3[1] = 3'd2;
    req_addr[0] = 32'h40; req_addr[1] = 32'h10;
    @(negedge clk);
    chk("post_rst_ptr_core", {30'd0, req_gnt}, 32'd1 << ref_ptr);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("post_rst_rsp", {30'd0, rsp_valid}, 32'd1);
    chk("post_rst_rdata", rsp_rdata, ref_word(32'h40));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
